// File: rtl/audio_frame_buffer.sv
// Ping-pong audio frame buffer: packs advance-strobed ADC samples into frames and
// holds each full frame for a consumer. Optional macro FRAME_DROP_COUNT_EN adds drop_count.
module audio_frame_buffer #(
    parameter int FRAME_LEN = 256,
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    input  logic [IN_W-1:0]              adc_sample,
    output logic                         frame_valid,
    output logic [7:0]                   frame_seq,
    input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
    output logic [OUT_W-1:0]             rd_data,
    input  logic                         frame_release,
    output logic                         overflow
`ifdef FRAME_DROP_COUNT_EN
    ,
    output logic [15:0]                  drop_count
`endif
);

    localparam int ADDR_W = $clog2(FRAME_LEN);

    typedef enum logic {FILL = 1'b0, HELD = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic                adv_q_reg;
    logic                wr_bank_reg;
    logic                rd_bank_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic                first_reg;
    logic [7:0]          seq_reg;
    logic                ovf_reg;
    logic [OUT_W-1:0]    rd_data_reg;
    logic [OUT_W-1:0]    mem [0:2*FRAME_LEN-1];

    logic accept;
    logic wr_en;
    logic frame_done;
    logic swap;
    logic drop;

    assign accept     = advance & ~adv_q_reg;
    assign wr_en      = accept & ~reset;
    assign frame_done = accept && (wr_ptr_reg == ADDR_W'(FRAME_LEN - 1));
    // A release arriving with the completing sample frees the held bank in time for the swap.
    assign swap       = frame_done && ((state_reg == FILL) || frame_release);
    assign drop       = frame_done && (state_reg == HELD) && !frame_release;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL:    if (swap) state_next = HELD;
            HELD:    if (frame_release && !swap) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        frame_valid = (state_reg == HELD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adv_q_reg   <= 1'b1;
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b1;
            wr_ptr_reg  <= '0;
            first_reg   <= 1'b1;
            seq_reg     <= 8'd0;
            ovf_reg     <= 1'b0;
        end else begin
            adv_q_reg <= advance;
            ovf_reg   <= drop;
            // Pointer wraps to 0 on both swap and drop since FRAME_LEN is a power of 2.
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (swap) begin
                rd_bank_reg <= wr_bank_reg;
                wr_bank_reg <= ~wr_bank_reg;
                if (first_reg) begin
                    first_reg <= 1'b0;
                end else begin
                    seq_reg <= seq_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_ptr_reg}] <= adc_sample[IN_W-1 -: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[{rd_bank_reg, rd_addr}];
        end
    end

    assign frame_seq = seq_reg;
    assign rd_data   = rd_data_reg;
    assign overflow  = ovf_reg;

`ifdef FRAME_DROP_COUNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= 16'd0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Randomized self-checking bench for audio_frame_buffer (FRAME_LEN=4) against a
// queue-based frame model; build with FRAME_DROP_COUNT_EN to also check drop_count.
module tb_audio_frame_buffer;

    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        advance = 1'b0;
    logic [23:0] adc_sample = '0;
    logic        frame_valid;
    logic [7:0]  frame_seq;
    logic [1:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        frame_release = 1'b0;
    logic        overflow;
`ifdef FRAME_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: samples collected per frame, last held frame, sequence, drops.
    logic [15:0] m_fill[$];
    logic [15:0] m_frame [FL];
    bit          m_held;
    bit          m_first;
    bit          m_last;
    logic [7:0]  m_seq;
    logic [15:0] m_drops;

    bit          exp_ovf;
    bit          exp_rd_ok;
    logic [15:0] exp_rd;

    audio_frame_buffer #(.FRAME_LEN(FL), .IN_W(24), .OUT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .advance(advance),
        .adc_sample(adc_sample),
        .frame_valid(frame_valid),
        .frame_seq(frame_seq),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_release(frame_release),
        .overflow(overflow)
`ifdef FRAME_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_fill.delete();
        m_held  = 0;
        m_first = 1;
        m_last  = 1;
        m_seq   = 8'd0;
        m_drops = 16'd0;
        for (int i = 0; i < FL; i++) m_frame[i] = '0;
    endtask

    // Drive one clock cycle of inputs and advance the model to the post-edge state.
    task automatic step(input bit adv, input logic [23:0] smp, input bit rel, input int addr);
        bit acc;
        bit done;
        exp_rd_ok     = m_held;
        exp_rd        = m_frame[addr];
        advance       = adv;
        adc_sample    = smp;
        frame_release = rel;
        rd_addr       = 2'(addr);
        acc    = adv && !m_last;
        m_last = adv;
        exp_ovf = 0;
        if (acc) m_fill.push_back(smp[23:8]);
        done = acc && (m_fill.size() == FL);
        if (done && (!m_held || rel)) begin
            for (int i = 0; i < FL; i++) m_frame[i] = m_fill[i];
            if (m_first) m_first = 0;
            else m_seq = m_seq + 8'd1;
            m_held = 1;
            $display("frame presented seq=%0d data=%h %h %h %h", m_seq,
                     m_frame[0], m_frame[1], m_frame[2], m_frame[3]);
        end else if (done) begin
            exp_ovf = 1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            $display("frame dropped, drops=%0d", m_drops);
        end else if (rel) begin
            m_held = 0;
        end
        if (done) m_fill.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset   = 1'b1;
        advance = 1'($urandom);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        n_vec++; if (frame_seq !== 8'd0) begin n_err++; $display("FAIL reset_seq: got %0d want 0", frame_seq); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_vec++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
`ifdef FRAME_DROP_COUNT_EN
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drops: got %0d want 0", drop_count); end
`endif
        step(0, 24'h0, 0, 0);
        $display("reset applied");
    endtask

    task automatic test_basic();
        logic [23:0] smp [FL];
        logic [15:0] want [FL];
        smp  = '{24'h123456, 24'hABCDEF, 24'h000100, 24'hFFFFFF};
        want = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
        for (int i = 0; i < FL; i++) begin
            step(1, smp[i], 0, 0);
            if (i < FL - 1) begin
                n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, frame_valid); end
            end
            step(0, 24'($urandom), 0, 0);
        end
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", frame_valid); end
        n_vec++; if (frame_seq !== 8'd0) begin n_err++; $display("FAIL basic_seq: got %0d want 0", frame_seq); end
        for (int i = 0; i < FL; i++) begin
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== want[i]) begin n_err++; $display("FAIL basic_rd[%0d]: got %h want %h", i, rd_data, want[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want [FL];
        for (int i = 0; i < FL; i++) want[i] = m_frame[i];
        for (int i = 0; i < FL; i++) begin
            step(1, 24'($urandom), 0, 0);
            n_vec++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL ovf_pulse[%0d]: got %b want %b", i, overflow, exp_ovf); end
            step(0, 24'($urandom), 0, 0);
            n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear[%0d]: got %b want 0", i, overflow); end
        end
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %b want 1", frame_valid); end
        n_vec++; if (frame_seq !== 8'd0) begin n_err++; $display("FAIL ovf_seq: got %0d want 0", frame_seq); end
`ifdef FRAME_DROP_COUNT_EN
        n_vec++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_drops: got %0d want 1", drop_count); end
`endif
        for (int i = 0; i < FL; i++) begin
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== want[i]) begin n_err++; $display("FAIL ovf_held_rd[%0d]: got %h want %h", i, rd_data, want[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] smp [FL];
        for (int i = 0; i < FL; i++) smp[i] = 24'($urandom);
        for (int i = 0; i < FL - 1; i++) begin
            step(1, smp[i], 0, 0);
            step(0, 24'($urandom), 0, 0);
        end
        step(1, smp[FL-1], 1, 0);
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", frame_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", overflow); end
        n_vec++; if (frame_seq !== 8'd1) begin n_err++; $display("FAIL b2b_seq: got %0d want 1", frame_seq); end
        step(0, 24'($urandom), 0, 0);
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid_hold: got %b want 1", frame_valid); end
        for (int i = 0; i < FL; i++) begin
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== smp[i][23:8]) begin n_err++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, rd_data, smp[i][23:8]); end
        end
    endtask

    task automatic test_level_advance();
        logic [23:0] smp [FL];
        for (int i = 0; i < FL; i++) smp[i] = 24'($urandom);
        step(0, 24'($urandom), 1, 0);
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL lvl_release: got %b want 0", frame_valid); end
        step(1, smp[0], 0, 0);
        repeat (19) step(1, 24'($urandom), 0, 0);
        step(0, 24'($urandom), 0, 0);
        step(1, smp[1], 0, 0);
        step(1, 24'($urandom), 0, 0);
        step(1, 24'($urandom), 0, 0);
        step(0, 24'($urandom), 0, 0);
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL lvl_two_only: got %b want 0", frame_valid); end
        for (int i = 2; i < FL; i++) begin
            step(1, smp[i], 0, 0);
            step(0, 24'($urandom), 0, 0);
        end
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL lvl_valid: got %b want 1", frame_valid); end
        n_vec++; if (frame_seq !== 8'd2) begin n_err++; $display("FAIL lvl_seq: got %0d want 2", frame_seq); end
        for (int i = 0; i < FL; i++) begin
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== smp[i][23:8]) begin n_err++; $display("FAIL lvl_rd[%0d]: got %h want %h", i, rd_data, smp[i][23:8]); end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] v;
        for (int i = 0; i < 2; i++) begin
            step(1, 24'($urandom), 1, 0);
            step(0, 24'($urandom), 0, 0);
        end
        apply_reset(2);
        step(0, 24'h0, 0, 0);
        for (int i = 1; i <= FL; i++) begin
            step(1, 24'(i << 8), 0, 0);
            step(0, 24'($urandom), 0, 0);
        end
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL mrst_valid: got %b want 1", frame_valid); end
        n_vec++; if (frame_seq !== 8'd0) begin n_err++; $display("FAIL mrst_seq: got %0d want 0", frame_seq); end
        for (int i = 0; i < FL; i++) begin
            v = 16'(i + 1);
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== v) begin n_err++; $display("FAIL mrst_rd[%0d]: got %h want %h", i, rd_data, v); end
        end
    endtask

    task automatic test_release_idle();
        step(0, 24'($urandom), 1, 0);
        step(0, 24'($urandom), 1, 0);
        n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", frame_valid); end
        n_vec++; if (frame_seq !== 8'd0) begin n_err++; $display("FAIL idle_seq: got %0d want 0", frame_seq); end
        for (int i = 0; i < FL; i++) begin
            step(1, 24'($urandom), 0, 0);
            n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL idle_ovf[%0d]: got %b want 0", i, overflow); end
            step(0, 24'($urandom), 0, 0);
        end
        n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL idle_next_valid: got %b want 1", frame_valid); end
        n_vec++; if (frame_seq !== 8'd1) begin n_err++; $display("FAIL idle_next_seq: got %0d want 1", frame_seq); end
        for (int i = 0; i < FL; i++) begin
            step(0, 24'($urandom), 0, i);
            n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL idle_rd[%0d]: got %h want %h", i, rd_data, exp_rd); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom), 24'($urandom), ($urandom_range(0, 11) == 0), int'($urandom_range(0, FL - 1)));
            n_vec++; if (frame_valid !== m_held) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, frame_valid, m_held); end
            n_vec++; if (overflow !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, overflow, exp_ovf); end
            n_vec++; if (frame_seq !== m_seq) begin n_err++; $display("FAIL rnd_seq@%0d: got %0d want %0d", c, frame_seq, m_seq); end
            if (exp_rd_ok) begin
                n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL rnd_rd@%0d: got %h want %h", c, rd_data, exp_rd); end
            end
`ifdef FRAME_DROP_COUNT_EN
            n_vec++; if (drop_count !== m_drops) begin n_err++; $display("FAIL rnd_drops@%0d: got %0d want %0d", c, drop_count, m_drops); end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_level_advance();
        test_mid_reset();
        test_release_idle();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
